// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - circular PC/instruction queue between fetch and decode
// Head is read combinationally; an empty queue presents pc 0 and a NOP to decode.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = AW'(0) + (AW+1)'(DEPTH);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign do_push   = in_valid && in_ready && !flush;
  assign do_pop    = out_valid && out_ready && !flush;

  // Storage carries no reset; the output mux hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_pc   = 32'h0;
    out_inst = NOP_INST;
    if (out_valid) begin
      out_pc   = pc_mem[rd_ptr];
      out_inst = inst_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - vector, corner-case and model-based stress bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic [2:0]  e_cnt;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [2:0] e_cnt, input logic e_ir,
                       input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_inst);
    checks++;
    if (count !== e_cnt || in_ready !== e_ir || out_valid !== e_ov ||
        out_pc !== e_pc || out_inst !== e_inst) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got cnt=%0d ir=%b ov=%b pc=%h inst=%h, want cnt=%0d ir=%b ov=%b pc=%h inst=%h",
                 name, count, in_ready, out_valid, out_pc, out_inst,
                 e_cnt, e_ir, e_ov, e_pc, e_inst);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy);
    flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] mq[$];
  logic [2:0]  m_cnt;
  logic        m_push, m_pop;
  logic [63:0] head;

  initial begin
    // fill, full, drain with wrap, empty pop, flush, push after flush
    vecs[0]  = '{1'b0, 1'b1, 32'd0,  32'hA0, 1'b0, 3'd1, 1'b1, 1'b1, 32'd0,  32'hA0};
    vecs[1]  = '{1'b0, 1'b1, 32'd4,  32'hA1, 1'b0, 3'd2, 1'b1, 1'b1, 32'd0,  32'hA0};
    vecs[2]  = '{1'b0, 1'b1, 32'd8,  32'hA2, 1'b0, 3'd3, 1'b1, 1'b1, 32'd0,  32'hA0};
    vecs[3]  = '{1'b0, 1'b1, 32'd12, 32'hA3, 1'b0, 3'd4, 1'b0, 1'b1, 32'd0,  32'hA0};
    vecs[4]  = '{1'b0, 1'b1, 32'd16, 32'hA4, 1'b0, 3'd4, 1'b0, 1'b1, 32'd0,  32'hA0};
    vecs[5]  = '{1'b0, 1'b1, 32'd16, 32'hA4, 1'b1, 3'd3, 1'b1, 1'b1, 32'd4,  32'hA1};
    vecs[6]  = '{1'b0, 1'b1, 32'd16, 32'hA4, 1'b1, 3'd3, 1'b1, 1'b1, 32'd8,  32'hA2};
    vecs[7]  = '{1'b0, 1'b1, 32'd20, 32'hA5, 1'b1, 3'd3, 1'b1, 1'b1, 32'd12, 32'hA3};
    vecs[8]  = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 3'd2, 1'b1, 1'b1, 32'd16, 32'hA4};
    vecs[9]  = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 3'd1, 1'b1, 1'b1, 32'd20, 32'hA5};
    vecs[10] = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 3'd0, 1'b1, 1'b0, 32'd0,  NOP};
    vecs[11] = '{1'b0, 1'b0, 32'd0,  32'h0,  1'b1, 3'd0, 1'b1, 1'b0, 32'd0,  NOP};
    vecs[12] = '{1'b0, 1'b1, 32'd0,  32'hB0, 1'b0, 3'd1, 1'b1, 1'b1, 32'd0,  32'hB0};
    vecs[13] = '{1'b0, 1'b1, 32'd4,  32'hB1, 1'b0, 3'd2, 1'b1, 1'b1, 32'd0,  32'hB0};
    vecs[14] = '{1'b1, 1'b1, 32'd8,  32'hB2, 1'b1, 3'd0, 1'b1, 1'b0, 32'd0,  NOP};
    vecs[15] = '{1'b0, 1'b1, 32'h20, 32'hC0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h20, 32'hC0};
    vecs[16] = '{1'b0, 1'b1, 32'h24, 32'hC1, 1'b1, 3'd1, 1'b1, 1'b1, 32'h24, 32'hC1};

    rstn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(); step();
    rstn = 1'b1;
    #2;
    check("reset", 3'd0, 1'b1, 1'b0, 32'h0, NOP);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ir, vecs[i].e_ov,
            vecs[i].e_pc, vecs[i].e_inst);
    end

    // async reset with three entries queued
    drive(1'b0, 1'b1, 32'h28, 32'hC2, 1'b0); step();
    drive(1'b0, 1'b1, 32'h2C, 32'hC3, 1'b0); step();
    check("pre_reset", 3'd3, 1'b1, 1'b1, 32'h24, 32'hC1);
    drive(1'b0, 1'b1, 32'h30, 32'hC4, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", 3'd0, 1'b1, 1'b0, 32'h0, NOP);
    step();
    check("reset_hold", 3'd0, 1'b1, 1'b0, 32'h0, NOP);
    rstn = 1'b1;
    drive(1'b0, 1'b1, 32'h40, 32'hD0, 1'b0);
    step();
    check("post_reset_push", 3'd1, 1'b1, 1'b1, 32'h40, 32'hD0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    check("post_reset_pop", 3'd0, 1'b1, 1'b0, 32'h0, NOP);

    // random stress against a queue model
    mq.delete();
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom, $urandom,
            $urandom_range(0, 1));
      m_push = in_valid && (mq.size() != DEPTH);
      m_pop  = out_ready && (mq.size() != 0);
      step();
      if (flush) mq.delete();
      else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back({in_pc, in_inst});
      end
      m_cnt = 3'(mq.size());
      if (mq.size() != 0) begin
        head = mq[0];
        check("stress", m_cnt, mq.size() != DEPTH, 1'b1, head[63:32], head[31:0]);
      end else
        check("stress", m_cnt, 1'b1, 1'b0, 32'h0, NOP);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
